// File: rtl/game_pkg.sv
// Shared game constants: sprite state codes (also the renderer's sprite select)
// and screen/sprite geometry.
package game_pkg;

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_FORWARD      = 4'd1;
  localparam logic [3:0] S_BACKWARD     = 4'd2;
  localparam logic [3:0] S_ATTACK_START = 4'd3;
  localparam logic [3:0] S_ATTACK_END   = 4'd4;
  localparam logic [3:0] S_ATTACK_PULL  = 4'd5;

  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 150;
  localparam int SPRITE_H = 157;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous button level, plus a rising-edge
// pulse derived from the synchronized level.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/player_ctrl.sv
// Per-player action/position controller feeding the sprite renderer; every
// output update happens on the vblank frame_tick only.
module player_ctrl #(
  parameter bit         FACING_RIGHT = 1'b1,
  parameter logic [9:0] X_INIT       = 10'd40,
  parameter logic [9:0] Y_POS        = 10'd300,
  parameter logic [9:0] X_MIN        = 10'd0,
  parameter logic [9:0] X_MAX        = 10'd490,
  parameter logic [3:0] FWD_SPEED    = 4'd3,
  parameter logic [3:0] BWD_SPEED    = 4'd2,
  parameter logic [4:0] START_FRAMES = 5'd6,
  parameter logic [4:0] END_FRAMES   = 5'd4,
  parameter logic [4:0] PULL_FRAMES  = 5'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_fwd,
  input  logic       btn_bwd,
  input  logic       btn_attack,
  output logic [3:0] state,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       hit_active,
  output logic       busy
);
  import game_pkg::*;

  if (FWD_SPEED == 4'd0 || BWD_SPEED == 4'd0 || START_FRAMES == 5'd0 ||
      END_FRAMES == 5'd0 || PULL_FRAMES == 5'd0) begin : g_param_check
    $error("player_ctrl: speed and frame-count parameters must be nonzero");
  end

  // Signed per-frame steps; the sign follows the player's facing direction.
  localparam logic signed [10:0] FWD_MAG = $signed({7'd0, FWD_SPEED});
  localparam logic signed [10:0] BWD_MAG = $signed({7'd0, BWD_SPEED});
  localparam logic signed [10:0] FWD_D   = FACING_RIGHT ? FWD_MAG : -FWD_MAG;
  localparam logic signed [10:0] BWD_D   = FACING_RIGHT ? -BWD_MAG : BWD_MAG;

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic signed [10:0] d);
    logic signed [10:0] sum;
    sum = $signed({1'b0, x}) + d;
    if (sum < $signed({1'b0, X_MIN})) return X_MIN;
    if (sum > $signed({1'b0, X_MAX})) return X_MAX;
    return sum[9:0];
  endfunction

  logic fwd;
  logic bwd;
  logic atk_rise;
  logic unused_fwd_rise;
  logic unused_bwd_rise;
  logic unused_atk_level;
  logic atk_req;
  logic [4:0] cnt;
  logic movable;

  btn_sync u_sync_fwd (.clk(clk), .rst(rst), .din(btn_fwd), .level(fwd), .rise(unused_fwd_rise));
  btn_sync u_sync_bwd (.clk(clk), .rst(rst), .din(btn_bwd), .level(bwd), .rise(unused_bwd_rise));
  btn_sync u_sync_atk (.clk(clk), .rst(rst), .din(btn_attack), .level(unused_atk_level),
                       .rise(atk_rise));

  assign movable = (state == S_IDLE) || (state == S_FORWARD) || (state == S_BACKWARD);
  assign posy    = Y_POS;

  // Attack request: latched on a press, consumed by the next tick that can act on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        atk_req <= 1'b0;
    else if (atk_rise)              atk_req <= 1'b1;
    else if (frame_tick && movable) atk_req <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      posx       <= X_INIT;
      cnt        <= 5'd0;
      hit_active <= 1'b0;
      busy       <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        S_IDLE, S_FORWARD, S_BACKWARD: begin
          if (atk_req) begin
            state <= S_ATTACK_START;
            cnt   <= START_FRAMES - 5'd1;
            busy  <= 1'b1;
          end else if (fwd && !bwd) begin
            state <= S_FORWARD;
            posx  <= step_x(posx, FWD_D);
          end else if (bwd && !fwd) begin
            state <= S_BACKWARD;
            posx  <= step_x(posx, BWD_D);
          end else begin
            state <= S_IDLE;
          end
        end
        S_ATTACK_START: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          else begin
            state      <= S_ATTACK_END;
            cnt        <= END_FRAMES - 5'd1;
            hit_active <= 1'b1;
          end
        end
        S_ATTACK_END: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          else begin
            state      <= S_ATTACK_PULL;
            cnt        <= PULL_FRAMES - 5'd1;
            hit_active <= 1'b0;
          end
        end
        S_ATTACK_PULL: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          hit_active <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
